// File: rtl/puf_pkg.sv
// Shared types and constants for the SRAM PUF read-out path.
// The combined RAM is 32 blocks of 256 words, selected by raddr[12:8].
package puf_pkg;

    localparam int PUF_ADDR_W        = 13;
    localparam int PUF_DATA_W        = 16;
    localparam int PUF_BLOCK_SEL_MSB = 12;
    localparam int PUF_BLOCK_SEL_LSB = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CAPT,
        SEND_LO,
        SEND_HI,
        CSUM_LO,
        CSUM_HI,
        FIN
    } reader_state_t;

endpackage

// File: rtl/puf_ram_reader.sv
// Sweeps the PUF RAM, streams each word low byte first,
// then appends a 16-bit XOR checksum of all words read.
module puf_ram_reader
    import puf_pkg::*;
#(
    parameter int ADDR_W     = PUF_ADDR_W,
    parameter int DATA_W     = PUF_DATA_W,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 8191
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(END_ADDR);

    reader_state_t     state;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] csum;

    // Byte mux is a pure function of registered state, so the byte
    // is stable for as long as a stall lasts.
    always_comb begin
        out_data = 8'h00;
        unique case (state)
            SEND_LO: out_data = word[7:0];
            SEND_HI: out_data = word[15:8];
            CSUM_LO: out_data = csum[7:0];
            CSUM_HI: out_data = csum[15:8];
            default: out_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            raddr     <= FIRST;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            word      <= '0;
            csum      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        raddr <= FIRST;
                        csum  <= '0;
                        busy  <= 1'b1;
                        state <= ADDR;
                    end
                end
                ADDR: state <= CAPT;
                // raddr must not move here: the RAM output mux
                // still decodes the block field of the current address.
                CAPT: begin
                    word      <= rdata;
                    csum      <= csum ^ rdata;
                    out_valid <= 1'b1;
                    state     <= SEND_LO;
                end
                SEND_LO: begin
                    if (out_ready) state <= SEND_HI;
                end
                SEND_HI: begin
                    if (out_ready) begin
                        if (raddr == LAST) begin
                            state <= CSUM_LO;
                        end else begin
                            raddr     <= raddr + ADDR_W'(1);
                            out_valid <= 1'b0;
                            state     <= ADDR;
                        end
                    end
                end
                CSUM_LO: begin
                    if (out_ready) state <= CSUM_HI;
                end
                CSUM_HI: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end
                end
                FIN: begin
                    raddr <= FIRST;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_ram_reader.sv
// Scoreboard bench for puf_ram_reader: three ranges (single word,
// block crossing, top of address space) against a 1-cycle RAM model.
module tb_puf_ram_reader;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        start_s = 0, start_m = 0, start_t = 0;
    logic        ready_s = 1, ready_m = 1, ready_t = 1;
    logic        busy_s, busy_m, busy_t;
    logic        done_s, done_m, done_t;
    logic        valid_s, valid_m, valid_t;
    logic [7:0]  data_s, data_m, data_t;
    logic [12:0] raddr_s, raddr_m, raddr_t;
    logic [15:0] rdata_s, rdata_m, rdata_t;
    logic [7:0]  aq_s, aq_m, aq_t;

    logic [7:0] exp_s[$];
    logic [7:0] exp_m[$];
    logic [7:0] exp_t[$];
    int xfer_s = 0, xfer_m = 0, xfer_t = 0;
    int dcnt_s = 0, dcnt_m = 0, dcnt_t = 0;

    function automatic logic [15:0] mem(input logic [12:0] a);
        case (a)
            13'd5:    return 16'hA55A;
            13'd255:  return 16'h1234;
            13'd256:  return 16'hBEEF;
            13'd257:  return 16'h0F0F;
            13'd8190: return 16'hC0DE;
            13'd8191: return 16'h7E57;
            default:  return {3'b101, a};
        endcase
    endfunction

    // RAM: word offset registered, block mux on the live address
    always @(posedge clk) begin
        aq_s <= raddr_s[7:0];
        aq_m <= raddr_m[7:0];
        aq_t <= raddr_t[7:0];
    end
    assign rdata_s = mem({raddr_s[12:8], aq_s});
    assign rdata_m = mem({raddr_m[12:8], aq_m});
    assign rdata_t = mem({raddr_t[12:8], aq_t});

    puf_ram_reader #(.START_ADDR(5), .END_ADDR(5)) u_s (
        .clk(clk), .resetn(resetn), .start(start_s),
        .busy(busy_s), .done(done_s), .raddr(raddr_s),
        .rdata(rdata_s), .out_data(data_s),
        .out_valid(valid_s), .out_ready(ready_s)
    );

    puf_ram_reader #(.START_ADDR(255), .END_ADDR(257)) u_m (
        .clk(clk), .resetn(resetn), .start(start_m),
        .busy(busy_m), .done(done_m), .raddr(raddr_m),
        .rdata(rdata_m), .out_data(data_m),
        .out_valid(valid_m), .out_ready(ready_m)
    );

    puf_ram_reader #(.START_ADDR(8190), .END_ADDR(8191)) u_t (
        .clk(clk), .resetn(resetn), .start(start_t),
        .busy(busy_t), .done(done_t), .raddr(raddr_t),
        .rdata(rdata_t), .out_data(data_t),
        .out_valid(valid_t), .out_ready(ready_t)
    );

    logic       stall_m = 1'b0;
    logic [7:0] stall_d_m = 8'h00;

    always @(negedge clk) begin
        logic [7:0] e;
        if (!resetn) begin
            stall_m = 1'b0;
        end else begin
            if (stall_m) begin
                checks++;
                if (valid_m !== 1'b1 || data_m !== stall_d_m) begin
                    errors++;
                    $display("FAIL m_stall_hold valid=%b data=%h required valid=1 data=%h",
                             valid_m, data_m, stall_d_m);
                end
            end
            if (valid_m && ready_m) begin
                checks++;
                xfer_m++;
                if (exp_m.size() == 0) begin
                    errors++;
                    $display("FAIL m_byte got=%h required=none", data_m);
                end else begin
                    e = exp_m.pop_front();
                    if (data_m !== e) begin
                        errors++;
                        $display("FAIL m_byte got=%h required=%h", data_m, e);
                    end
                end
            end
            stall_m = valid_m && !ready_m;
            stall_d_m = data_m;
            if (done_m) dcnt_m++;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (resetn && valid_s && ready_s) begin
            checks++;
            xfer_s++;
            e = (exp_s.size() != 0) ? exp_s.pop_front() : 8'hxx;
            if (data_s !== e) begin
                errors++;
                $display("FAIL s_byte got=%h required=%h", data_s, e);
            end
        end
        if (resetn && done_s) dcnt_s++;
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (resetn && valid_t && ready_t) begin
            checks++;
            xfer_t++;
            e = (exp_t.size() != 0) ? exp_t.pop_front() : 8'hxx;
            if (data_t !== e) begin
                errors++;
                $display("FAIL t_byte got=%h required=%h", data_t, e);
            end
        end
        if (resetn && done_t) dcnt_t++;
    end

    task automatic push_multi();
        exp_m.push_back(8'h34); exp_m.push_back(8'h12);
        exp_m.push_back(8'hEF); exp_m.push_back(8'hBE);
        exp_m.push_back(8'h0F); exp_m.push_back(8'h0F);
        exp_m.push_back(8'hD4); exp_m.push_back(8'hA3);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (valid_s !== 0 || valid_m !== 0 || valid_t !== 0) begin
            errors++;
            $display("FAIL rst_valid got=%b%b%b required=000", valid_s, valid_m, valid_t);
        end
        checks++;
        if (busy_s !== 0 || busy_m !== 0 || done_m !== 0 || data_m !== 8'h00) begin
            errors++;
            $display("FAIL rst_outs busy=%b done=%b data=%h required 0 0 00",
                     busy_m, done_m, data_m);
        end
        checks++;
        if (raddr_s !== 13'd5 || raddr_m !== 13'd255 || raddr_t !== 13'd8190) begin
            errors++;
            $display("FAIL rst_raddr got=%0d %0d %0d required=5 255 8190",
                     raddr_s, raddr_m, raddr_t);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_single();
        int c;
        exp_s.push_back(8'h5A); exp_s.push_back(8'hA5);
        exp_s.push_back(8'h5A); exp_s.push_back(8'hA5);
        @(negedge clk); start_s = 1'b1;
        @(posedge clk); #1; start_s = 1'b0;
        checks++;
        if (busy_s !== 1'b1) begin
            errors++;
            $display("FAIL s_busy got=%b required=1", busy_s);
        end
        for (c = 1; c <= 40; c++) begin
            if (done_s) break;
            @(posedge clk); #1;
        end
        checks++;
        if (c != 7) begin
            errors++;
            $display("FAIL s_done_cycle got=%0d required=7", c);
        end
        @(posedge clk); #1;
        checks++;
        if (raddr_s !== 13'd5 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL s_end raddr=%0d busy=%b required 5 0", raddr_s, busy_s);
        end
        checks++;
        if (exp_s.size() != 0 || xfer_s != 4 || dcnt_s != 1) begin
            errors++;
            $display("FAIL s_count left=%0d xfer=%0d done=%0d required 0 4 1",
                     exp_s.size(), xfer_s, dcnt_s);
        end
    endtask

    task automatic test_multi_block();
        int c;
        int x0;
        x0 = xfer_m;
        push_multi();
        ready_m = 1'b1;
        @(negedge clk); start_m = 1'b1;
        @(posedge clk); #1; start_m = 1'b0;
        for (c = 1; c <= 40; c++) begin
            if (c <= 12) begin
                checks++;
                if (raddr_m !== 13'(255 + (c - 1) / 4)) begin
                    errors++;
                    $display("FAIL m_raddr cycle=%0d got=%0d required=%0d",
                             c, raddr_m, 255 + (c - 1) / 4);
                end
            end
            if (done_m) break;
            @(posedge clk); #1;
        end
        checks++;
        if (c != 15) begin
            errors++;
            $display("FAIL m_done_cycle got=%0d required=15", c);
        end
        @(posedge clk); #1;
        checks++;
        if (exp_m.size() != 0 || xfer_m - x0 != 8) begin
            errors++;
            $display("FAIL m_count left=%0d xfer=%0d required 0 8",
                     exp_m.size(), xfer_m - x0);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int x0;
        int d0;
        x0 = xfer_m;
        d0 = dcnt_m;
        push_multi();
        @(negedge clk); start_m = 1'b1;
        @(posedge clk); #1; start_m = 1'b0;
        for (n = 0; n < 600; n++) begin
            if (dcnt_m != d0) break;
            ready_m = ($urandom_range(0, 99) < 30);
            @(posedge clk); #1;
        end
        ready_m = 1'b1;
        checks++;
        if (n >= 600) begin
            errors++;
            $display("FAIL bp_timeout cycles=%0d required done", n);
        end
        checks++;
        if (exp_m.size() != 0 || xfer_m - x0 != 8) begin
            errors++;
            $display("FAIL bp_count left=%0d xfer=%0d required 0 8",
                     exp_m.size(), xfer_m - x0);
        end
    endtask

    task automatic test_start_busy();
        int x0;
        int d0;
        x0 = xfer_m;
        d0 = dcnt_m;
        push_multi();
        ready_m = 1'b1;
        @(negedge clk); start_m = 1'b1;
        @(posedge clk); #1; start_m = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            start_m = (c == 5) || done_m;
            @(posedge clk); #1;
        end
        start_m = 1'b0;
        checks++;
        if (dcnt_m - d0 != 1 || xfer_m - x0 != 8) begin
            errors++;
            $display("FAIL busy_start done=%0d xfer=%0d required 1 8",
                     dcnt_m - d0, xfer_m - x0);
        end
        checks++;
        if (busy_m !== 1'b0 || exp_m.size() != 0) begin
            errors++;
            $display("FAIL busy_idle busy=%b left=%0d required 0 0",
                     busy_m, exp_m.size());
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        int x0;
        int n;
        d0 = dcnt_m;
        exp_m.push_back(8'h34);
        ready_m = 1'b0;
        @(negedge clk); start_m = 1'b1;
        @(posedge clk); #1; start_m = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; ready_m = 1'b1;
        @(posedge clk); #1; ready_m = 1'b0;
        checks++;
        if (valid_m !== 1'b1 || data_m !== 8'h12) begin
            errors++;
            $display("FAIL rm_send_hi valid=%b data=%h required 1 12", valid_m, data_m);
        end
        #2; resetn = 1'b0;
        #1;
        checks++;
        if (valid_m !== 0 || busy_m !== 0 || raddr_m !== 13'd255) begin
            errors++;
            $display("FAIL rm_async valid=%b busy=%b raddr=%0d required 0 0 255",
                     valid_m, busy_m, raddr_m);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (dcnt_m != d0 || exp_m.size() != 0) begin
            errors++;
            $display("FAIL rm_no_done done=%0d left=%0d required 0 0",
                     dcnt_m - d0, exp_m.size());
        end
        x0 = xfer_m;
        push_multi();
        ready_m = 1'b1;
        @(negedge clk); start_m = 1'b1;
        @(posedge clk); #1; start_m = 1'b0;
        for (n = 0; n < 60; n++) begin
            if (dcnt_m != d0) break;
            @(posedge clk); #1;
        end
        checks++;
        if (dcnt_m - d0 != 1 || xfer_m - x0 != 8 || exp_m.size() != 0) begin
            errors++;
            $display("FAIL rm_replay done=%0d xfer=%0d left=%0d required 1 8 0",
                     dcnt_m - d0, xfer_m - x0, exp_m.size());
        end
    endtask

    task automatic test_top_range();
        int dc;
        logic [12:0] mx;
        logic zero;
        dc = 0;
        mx = 13'd0;
        zero = 1'b0;
        exp_t.push_back(8'hDE); exp_t.push_back(8'hC0);
        exp_t.push_back(8'h57); exp_t.push_back(8'h7E);
        exp_t.push_back(8'h89); exp_t.push_back(8'hBE);
        @(negedge clk); start_t = 1'b1;
        @(posedge clk); #1; start_t = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (raddr_t > mx) mx = raddr_t;
            if (raddr_t == 13'd0) zero = 1'b1;
            if (done_t && dc == 0) dc = c;
            @(posedge clk); #1;
        end
        checks++;
        if (mx !== 13'd8191 || zero) begin
            errors++;
            $display("FAIL top_raddr max=%0d zero=%b required 8191 0", mx, zero);
        end
        checks++;
        if (dc != 11 || dcnt_t != 1 || busy_t !== 1'b0) begin
            errors++;
            $display("FAIL top_done cycle=%0d count=%0d busy=%b required 11 1 0",
                     dc, dcnt_t, busy_t);
        end
        checks++;
        if (xfer_t != 6 || exp_t.size() != 0) begin
            errors++;
            $display("FAIL top_count xfer=%0d left=%0d required 6 0",
                     xfer_t, exp_t.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_block();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_top_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
